// File: rtl/mem_responder.sv
// Two-port (fetch / data) responder in front of a single-port 256x8 array.
// Round-robin arbitration, IDLE -> ACCESS -> ACK, one transaction per three cycles.
module mem_responder (
  input  logic       clk,
  input  logic       rst,
  input  logic       f_req,
  input  logic [7:0] f_addr,
  output logic       f_ack,
  output logic [7:0] f_rdata,
  input  logic       d_req,
  input  logic       d_we,
  input  logic [7:0] d_addr,
  input  logic [7:0] d_wdata,
  output logic       d_ack,
  output logic [7:0] d_rdata,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t     state_q, state_d;
  logic       sel_d_q, sel_d_d;
  logic       last_d_q, last_d_d;
  logic [7:0] addr_q, addr_d;
  logic       we_q, we_d;
  logic [7:0] wdata_q, wdata_d;
  logic       f_ack_q, f_ack_d;
  logic       d_ack_q, d_ack_d;
  logic [7:0] f_rdata_q, f_rdata_d;
  logic [7:0] d_rdata_q, d_rdata_d;
  logic       grant_d;
  logic       mem_we;
  logic [7:0] mem_rd;

  logic [7:0] mem [256];

  assign mem_rd  = mem[addr_q];
  assign f_ack   = f_ack_q;
  assign d_ack   = d_ack_q;
  assign f_rdata = f_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    sel_d_d   = sel_d_q;
    last_d_d  = last_d_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    f_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    grant_d   = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (f_req || d_req) begin
          // On conflict the port that did not win last time is served.
          grant_d  = d_req && (!f_req || !last_d_q);
          sel_d_d  = grant_d;
          last_d_d = grant_d;
          addr_d   = grant_d ? d_addr : f_addr;
          we_d     = grant_d && d_we;
          wdata_d  = d_wdata;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (sel_d_q) begin
          d_ack_d = 1'b1;
          if (we_q) mem_we = 1'b1;
          else      d_rdata_d = mem_rd;
        end else begin
          f_ack_d   = 1'b1;
          f_rdata_d = mem_rd;
        end
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_d_q   <= 1'b0;
      last_d_q  <= 1'b0;
      addr_q    <= 8'h00;
      we_q      <= 1'b0;
      wdata_q   <= 8'h00;
      f_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      f_rdata_q <= 8'h00;
      d_rdata_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      sel_d_q   <= sel_d_d;
      last_d_q  <= last_d_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      f_ack_q   <= f_ack_d;
      d_ack_q   <= d_ack_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Array is never reset; a write caught by reset in ACCESS is discarded.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[addr_q] <= wdata_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic
// checked against a plain array model of the memory and a round-robin grant model.
module tb_mem_responder;
  logic       clk = 1'b0;
  logic       rst, f_req, d_req, d_we;
  logic [7:0] f_addr, d_addr, d_wdata;
  logic       f_ack, d_ack, busy;
  logic [7:0] f_rdata, d_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] model [256];
  logic [7:0] exp_f, exp_d;
  logic       last_d;

  mem_responder dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one data transaction from IDLE; returns cycles to ack, rdata, and ack one cycle later.
  task automatic d_xact(input logic we, input logic [7:0] a, input logic [7:0] wd,
                        output int lat, output logic [7:0] rd, output logic ack2);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; lat = 0;
    do begin tick(); lat++; end while (!d_ack && lat < 20);
    d_req = 1'b0;
    rd = d_rdata;
    tick();
    ack2 = d_ack;
    last_d = 1'b1;
  endtask

  task automatic f_xact(input logic [7:0] a, output int lat, output logic [7:0] rd,
                        output logic ack2);
    f_req = 1'b1; f_addr = a; lat = 0;
    do begin tick(); lat++; end while (!f_ack && lat < 20);
    f_req = 1'b0;
    rd = f_rdata;
    tick();
    ack2 = f_ack;
    last_d = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    f_addr = 8'h00; d_addr = 8'h00; d_wdata = 8'h00;
    tick(); tick();
    n_cmp++; if (f_ack !== 1'b0) begin n_err++; $display("FAIL rst_f_ack: got %b want 0", f_ack); end
    n_cmp++; if (d_ack !== 1'b0) begin n_err++; $display("FAIL rst_d_ack: got %b want 0", d_ack); end
    n_cmp++; if (f_rdata !== 8'h00) begin n_err++; $display("FAIL rst_f_rdata: got %h want 00", f_rdata); end
    n_cmp++; if (d_rdata !== 8'h00) begin n_err++; $display("FAIL rst_d_rdata: got %h want 00", d_rdata); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst = 1'b0;
    exp_f = 8'h00; exp_d = 8'h00; last_d = 1'b0;
  endtask

  task automatic test_post_reset_write();
    int lat; logic [7:0] rd; logic a2;
    d_xact(1'b1, 8'h10, 8'h5A, lat, rd, a2);
    model[8'h10] = 8'h5A;
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL wr_lat: got %0d want 2", lat); end
    n_cmp++; if (rd !== 8'h00) begin n_err++; $display("FAIL wr_d_rdata: got %h want 00", rd); end
    n_cmp++; if (a2 !== 1'b0) begin n_err++; $display("FAIL wr_ack_width: got %b want 0", a2); end
    f_xact(8'h10, lat, rd, a2);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL fetch_lat: got %0d want 2", lat); end
    n_cmp++; if (rd !== 8'h5A) begin n_err++; $display("FAIL fetch_rdata: got %h want 5a", rd); end
    n_cmp++; if (a2 !== 1'b0) begin n_err++; $display("FAIL fetch_ack_width: got %b want 0", a2); end
    exp_f = 8'h5A;
  endtask

  task automatic test_fill();
    int lat; logic [7:0] rd, v; logic a2; int bad;
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      v = 8'($urandom);
      d_xact(1'b1, 8'(a), v, lat, rd, a2);
      model[a] = v;
      if (lat != 2 || rd !== exp_d || a2 !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL fill_writes: got %0d bad writes want 0", bad); end
  endtask

  task automatic test_conflict();
    int lat, fa, da; logic [7:0] rd; logic a2, coinc;
    d_xact(1'b1, 8'h20, 8'h33, lat, rd, a2);
    model[8'h20] = 8'h33;
    rst = 1'b1; tick(); rst = 1'b0;
    exp_f = 8'h00; exp_d = 8'h00; last_d = 1'b0;
    f_req = 1'b1; f_addr = 8'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    fa = 0; da = 0; coinc = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (f_ack && d_ack) coinc = 1'b1;
      if (d_ack && da == 0) begin da = k; d_req = 1'b0; end
      if (f_ack && fa == 0) begin fa = k; f_req = 1'b0; end
    end
    n_cmp++; if (da !== 2) begin n_err++; $display("FAIL conf_d_cycle: got %0d want 2", da); end
    n_cmp++; if (fa !== 5) begin n_err++; $display("FAIL conf_f_cycle: got %0d want 5", fa); end
    n_cmp++; if (d_rdata !== model[8'h20]) begin n_err++; $display("FAIL conf_d_rdata: got %h want %h", d_rdata, model[8'h20]); end
    n_cmp++; if (f_rdata !== model[8'h20]) begin n_err++; $display("FAIL conf_f_rdata: got %h want %h", f_rdata, model[8'h20]); end
    n_cmp++; if (coinc !== 1'b0) begin n_err++; $display("FAIL conf_coincident: got %b want 0", coinc); end
    exp_f = model[8'h20]; exp_d = model[8'h20]; last_d = 1'b0;
  endtask

  task automatic test_back_to_back();
    int grants, k, order_bad, data_bad, idle_bad, coinc;
    logic want_d, busy_prev;
    grants = 0; k = 0; order_bad = 0; data_bad = 0; idle_bad = 0; coinc = 0;
    busy_prev = 1'b1;
    f_addr = 8'($urandom); d_addr = 8'($urandom); d_we = 1'($urandom); d_wdata = 8'($urandom);
    f_req = 1'b1; d_req = 1'b1;
    while (grants < 8 && k < 60) begin
      tick(); k++;
      if (!f_req) begin f_req = 1'b1; f_addr = 8'($urandom); end
      if (!d_req) begin d_req = 1'b1; d_addr = 8'($urandom); d_we = 1'($urandom); d_wdata = 8'($urandom); end
      if (!busy && !busy_prev && k > 1) idle_bad++;
      busy_prev = busy;
      if (f_ack && d_ack) coinc++;
      if (f_ack || d_ack) begin
        want_d = !last_d;
        if (d_ack !== want_d) order_bad++;
        last_d = d_ack;
        grants++;
        if (d_ack) begin
          if (d_we) model[d_addr] = d_wdata;
          else      exp_d = model[d_addr];
          if (d_rdata !== exp_d || f_rdata !== exp_f) data_bad++;
          d_req = 1'b0;
        end else begin
          exp_f = model[f_addr];
          if (f_rdata !== exp_f || d_rdata !== exp_d) data_bad++;
          f_req = 1'b0;
        end
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    tick(); tick();
    n_cmp++; if (grants !== 8) begin n_err++; $display("FAIL b2b_grants: got %0d want 8", grants); end
    n_cmp++; if (k !== 23) begin n_err++; $display("FAIL b2b_cycles: got %0d want 23", k); end
    n_cmp++; if (order_bad !== 0) begin n_err++; $display("FAIL b2b_order: got %0d wrong grants want 0", order_bad); end
    n_cmp++; if (data_bad !== 0) begin n_err++; $display("FAIL b2b_data: got %0d bad rdata want 0", data_bad); end
    n_cmp++; if (idle_bad !== 0) begin n_err++; $display("FAIL b2b_idle: got %0d long idles want 0", idle_bad); end
    n_cmp++; if (coinc !== 0) begin n_err++; $display("FAIL b2b_coincident: got %0d want 0", coinc); end
  endtask

  task automatic test_boundary();
    int lat; logic [7:0] rd; logic a2;
    d_xact(1'b1, 8'hFF, 8'hC3, lat, rd, a2); model[8'hFF] = 8'hC3;
    d_xact(1'b1, 8'h00, 8'h11, lat, rd, a2); model[8'h00] = 8'h11;
    d_xact(1'b0, 8'hFF, 8'h00, lat, rd, a2);
    n_cmp++; if (rd !== 8'hC3) begin n_err++; $display("FAIL bnd_ff: got %h want c3", rd); end
    d_xact(1'b0, 8'h00, 8'h00, lat, rd, a2);
    n_cmp++; if (rd !== 8'h11) begin n_err++; $display("FAIL bnd_00: got %h want 11", rd); end
    f_xact(8'hFF, lat, rd, a2);
    n_cmp++; if (rd !== 8'hC3) begin n_err++; $display("FAIL bnd_f_ff: got %h want c3", rd); end
    exp_d = 8'h11; exp_f = 8'hC3;
  endtask

  task automatic test_reset_abort();
    int lat; logic [7:0] rd; logic a2;
    d_xact(1'b1, 8'h40, 8'h77, lat, rd, a2); model[8'h40] = 8'h77;
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h40; d_wdata = 8'h99;
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_access: got %b want 1", busy); end
    rst = 1'b1; d_req = 1'b0;
    tick();
    rst = 1'b0;
    n_cmp++; if (d_ack !== 1'b0) begin n_err++; $display("FAIL abort_d_ack: got %b want 0", d_ack); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (f_rdata !== 8'h00) begin n_err++; $display("FAIL abort_f_rdata: got %h want 00", f_rdata); end
    n_cmp++; if (d_rdata !== 8'h00) begin n_err++; $display("FAIL abort_d_rdata: got %h want 00", d_rdata); end
    tick();
    n_cmp++; if (d_ack !== 1'b0) begin n_err++; $display("FAIL abort_late_ack: got %b want 0", d_ack); end
    exp_f = 8'h00; exp_d = 8'h00; last_d = 1'b0;
    d_xact(1'b0, 8'h40, 8'h00, lat, rd, a2);
    n_cmp++; if (rd !== model[8'h40]) begin n_err++; $display("FAIL abort_preserved: got %h want %h", rd, model[8'h40]); end
    exp_d = model[8'h40];
  endtask

  task automatic test_latch();
    int lat; logic [7:0] rd; logic a2;
    d_xact(1'b1, 8'h51, 8'h3C, lat, rd, a2); model[8'h51] = 8'h3C;
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h50; d_wdata = 8'hA5;
    tick();
    d_addr = 8'h51; d_wdata = 8'h00;
    tick();
    n_cmp++; if (d_ack !== 1'b1) begin n_err++; $display("FAIL latch_ack: got %b want 1", d_ack); end
    d_req = 1'b0; tick();
    model[8'h50] = 8'hA5;
    d_xact(1'b0, 8'h50, 8'h00, lat, rd, a2);
    n_cmp++; if (rd !== model[8'h50]) begin n_err++; $display("FAIL latch_50: got %h want %h", rd, model[8'h50]); end
    d_xact(1'b0, 8'h51, 8'h00, lat, rd, a2);
    n_cmp++; if (rd !== model[8'h51]) begin n_err++; $display("FAIL latch_51: got %h want %h", rd, model[8'h51]); end
    exp_d = model[8'h51];
  endtask

  task automatic test_random();
    int lat; logic [7:0] rd, a, v; logic a2, we;
    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom); v = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        f_xact(a, lat, rd, a2);
        exp_f = model[a];
        n_cmp++; if (lat !== 2 || rd !== exp_f || d_rdata !== exp_d || a2 !== 1'b0) begin
          n_err++; $display("FAIL rnd_fetch[%0d] a=%h: lat %0d rd %h d_rd %h ack2 %b want lat 2 rd %h d_rd %h ack2 0", i, a, lat, rd, d_rdata, a2, exp_f, exp_d);
        end
      end else begin
        we = 1'($urandom);
        d_xact(we, a, v, lat, rd, a2);
        if (we) model[a] = v; else exp_d = model[a];
        n_cmp++; if (lat !== 2 || rd !== exp_d || f_rdata !== exp_f || a2 !== 1'b0) begin
          n_err++; $display("FAIL rnd_data[%0d] we=%b a=%h: lat %0d rd %h f_rd %h ack2 %b want lat 2 rd %h f_rd %h ack2 0", i, we, a, lat, rd, f_rdata, a2, exp_d, exp_f);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_post_reset_write();
    test_fill();
    test_conflict();
    test_back_to_back();
    test_boundary();
    test_reset_abort();
    test_latch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 f_req  in  1  instruction-fetch request; held high until f_ack.
REQ-005 f_addr  in  8  fetch byte address; stable while f_req high.
REQ-006 f_ack  out  1  one-cycle fetch completion pulse.
REQ-007 f_rdata  out  8  fetched byte; registered, held until next fetch completion.
REQ-008 d_req  in  1  data (LOAD/STORE) request; held high until d_ack.
REQ-009 d_we  in  1  1 = write, 0 = read; stable while d_req high.
REQ-010 d_addr  in  8  data byte address; stable while d_req high.
REQ-011 d_wdata  in  8  write byte; stable while d_req high.
REQ-012 d_ack  out  1  one-cycle data completion pulse.
REQ-013 d_rdata  out  8  loaded byte; registered, held until next data read completion.
REQ-014 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-015 Storage SHALL be a single-port 256x8 array indexed by the full 8-bit address, with no out-of-range case; 0x00 and 0xFF are ordinary locations.
REQ-016 The FSM SHALL have three states: IDLE, ACCESS, ACK; encoding free.
REQ-017 IDLE, edge E0, any req sampled high: latch granted port, address, d_we, d_wdata; go ACCESS. No req: stay IDLE.
REQ-018 ACCESS, edge E1: perform the array access; for reads, load the granted port's rdata register; set the granted port's ack; go ACK.
REQ-019 ACK, edge E2: clear ack; go IDLE unconditionally; requests are only sampled in IDLE.
REQ-020 Latency: ack is high exactly one cycle (E1 to E2); a transaction occupies 3 cycles; maximum throughput is one transaction per 3 cycles.
REQ-021 Requesters SHALL drop req by edge E3; req still high in IDLE at E3 SHALL be treated as a new transaction.
REQ-022 Write (d_we=1): array[d_addr] <= d_wdata at E1; d_ack pulses as for reads; d_rdata unchanged.
REQ-023 The fetch port SHALL be read-only; f_rdata changes only at a fetch E1.
REQ-024 Arbitration: f_req and d_req both high in IDLE: grant the port not granted most recently (round-robin); loser's req stays pending and is served next.
REQ-025 Only one request pending: it SHALL be granted regardless of round-robin state.
REQ-026 The last-grant register SHALL update only on a grant.
REQ-027 f_ack and d_ack SHALL never be high in the same cycle.
REQ-028 Latched address/data SHALL be used for the access; input changes after E0 have no effect on the current transaction.

Reset
REQ-029 rst high at an edge: state IDLE; f_ack=0, d_ack=0, f_rdata=0x00, d_rdata=0x00, busy=0; last-grant = fetch, so data wins the first conflict.
REQ-030 Reset SHALL take priority over every transition; a transaction in ACCESS when rst is sampled SHALL be dropped with no ack, and its write SHALL NOT commit.
REQ-031 Array contents SHALL NOT be reset; they are preserved across reset and undefined at power-up.

Verification
REQ-032 Post-reset write: d_req, d_we=1, d_addr=0x10, d_wdata=0x5A -> d_ack one cycle after ACCESS, d_rdata=0x00; then fetch f_addr=0x10 -> f_ack pulse, f_rdata=0x5A.
REQ-033 f_req and d_req raised together after reset, both reading addr 0x20 (holding 0x33) -> d_ack first (cycle 2), f_ack 3 cycles later (cycle 5), both rdata=0x33, acks never coincident.
REQ-034 f_req and d_req held high continuously, each port dropping and re-raising req immediately after its ack -> grant order D,F,D,F; busy low only for single IDLE cycles.
REQ-035 Boundary: write 0xC3 to 0xFF, 0x11 to 0x00 -> read 0xFF returns 0xC3, read 0x00 returns 0x11; no aliasing.
REQ-036 Addr 0x40 holds 0x77; write 0x99 to 0x40, rst asserted for the ACCESS edge -> no d_ack, state IDLE, both rdata=0x00; subsequent read 0x40 returns 0x77.
REQ-037 d_addr/d_wdata changed in the ACCESS cycle -> memory updated with E0-latched values only.
